// File: rtl/face_coords_uart_tx.sv
// Face-coordinate return path: buffers detector results and end-of-image markers
// in a small FIFO and serializes each as a checksummed 8N1 UART frame.
module face_coords_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [7:0] EOI_BYTE     = 8'h5A
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0][31:0] face_coords,
    input  logic             face_coords_ready,
    input  logic             img_done,
    output logic             tx,
    output logic             busy,
    output logic             fifo_full,
    output logic [15:0]      dropped_count
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNTW-1:0] DEPTH_C     = CNTW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   BIT_LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      FACE_LAST_C = 5'd17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Payload byte k (0..15): word k/4, sent MSB byte first within the word.
    function automatic logic [7:0] payload_byte(input logic [127:0] coords, input logic [3:0] k);
        logic [6:0] base;
        base = {k[3:2], 5'd0} + {2'b00, ~k[1:0], 3'd0};
        return coords[base +: 8];
    endfunction

    function automatic logic [7:0] calc_chk(input logic [127:0] coords);
        logic [7:0] sum;
        sum = 8'd0;
        for (int k = 0; k < 16; k++) begin
            sum = sum + payload_byte(coords, 4'(k));
        end
        return sum;
    endfunction

    logic [128:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   eoi_addr_s;
    logic [CNTW-1:0] count_r;
    logic [CNTW-1:0] count_next_s;
    logic [CNTW-1:0] free_s;
    logic            fifo_empty_s;
    logic            face_ok_s;
    logic            eoi_ok_s;
    logic [1:0]      push_num_s;
    logic [1:0]      drop_num_s;
    logic [16:0]     dropped_sum_s;
    logic [15:0]     dropped_r;
    logic            fifo_full_r;

    state_t          state_r;
    state_t          state_next_s;
    logic            pop_s;
    logic [128:0]    entry_r;
    logic [7:0]      chk_r;
    logic [7:0]      cur_byte_s;
    logic [4:0]      last_idx_s;
    logic [4:0]      byte_idx_r;
    logic [4:0]      byte_idx_next_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_idx_next_s;
    logic [CW-1:0]   clk_cnt_r;
    logic [CW-1:0]   clk_cnt_next_s;
    logic            bit_done_s;
    logic            tx_next_s;
    logic            tx_r;
    logic            busy_r;

    // Push acceptance: free slots include the slot released by a same-edge pop.
    always_comb begin
        fifo_empty_s = (count_r == {CNTW{1'b0}});
        free_s       = DEPTH_C - count_r + CNTW'(pop_s);
        face_ok_s    = face_coords_ready & (free_s != {CNTW{1'b0}});
        if (face_ok_s) begin
            eoi_ok_s = img_done & (free_s >= CNTW'(2));
        end else begin
            eoi_ok_s = img_done & (free_s >= CNTW'(1));
        end
        push_num_s    = {1'b0, face_ok_s} + {1'b0, eoi_ok_s};
        drop_num_s    = {1'b0, face_coords_ready & ~face_ok_s} + {1'b0, img_done & ~eoi_ok_s};
        count_next_s  = count_r - CNTW'(pop_s) + CNTW'(push_num_s);
        eoi_addr_s    = wr_ptr_r + AW'(face_ok_s);
        dropped_sum_s = {1'b0, dropped_r} + 17'(drop_num_s);
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (face_ok_s) begin
            mem_r[wr_ptr_r] <= {1'b0, face_coords};
        end
        if (eoi_ok_s) begin
            mem_r[eoi_addr_s] <= {1'b1, 128'd0};
        end
    end

    // FIFO pointers, occupancy, full flag and saturating drop counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CNTW{1'b0}};
            fifo_full_r <= 1'b0;
            dropped_r   <= 16'd0;
        end else begin
            wr_ptr_r    <= wr_ptr_r + AW'(push_num_s);
            rd_ptr_r    <= rd_ptr_r + AW'(pop_s);
            count_r     <= count_next_s;
            fifo_full_r <= (count_next_s == DEPTH_C);
            dropped_r   <= dropped_sum_s[16] ? 16'hFFFF : dropped_sum_s[15:0];
        end
    end

    // Current frame entry, captured on the pop edge; checksum formed during LOAD.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_r <= 129'd0;
            chk_r   <= 8'd0;
        end else begin
            if (pop_s) begin
                entry_r <= mem_r[rd_ptr_r];
            end
            if (state_r == LOAD) begin
                chk_r <= calc_chk(entry_r[127:0]);
            end
        end
    end

    // Byte currently being serialized and the index of the frame's final byte.
    always_comb begin
        last_idx_s = entry_r[128] ? 5'd0 : FACE_LAST_C;
        if (entry_r[128]) begin
            cur_byte_s = EOI_BYTE;
        end else if (byte_idx_r == 5'd0) begin
            cur_byte_s = SYNC_BYTE;
        end else if (byte_idx_r == FACE_LAST_C) begin
            cur_byte_s = chk_r;
        end else begin
            cur_byte_s = payload_byte(entry_r[127:0], 4'(byte_idx_r - 5'd1));
        end
    end

    assign bit_done_s = (clk_cnt_r == BIT_LAST_C);

    // Transmit FSM next-state, counters, pop request and next tx level.
    always_comb begin
        state_next_s    = state_r;
        pop_s           = 1'b0;
        byte_idx_next_s = byte_idx_r;
        bit_idx_next_s  = bit_idx_r;
        clk_cnt_next_s  = clk_cnt_r;
        tx_next_s       = 1'b1;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                byte_idx_next_s = 5'd0;
                clk_cnt_next_s  = {CW{1'b0}};
                state_next_s    = START;
            end
            START: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {CW{1'b0}};
                    bit_idx_next_s = 3'd0;
                    state_next_s   = DATA;
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CW'(1);
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {CW{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CW'(1);
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {CW{1'b0}};
                    if (byte_idx_r < last_idx_s) begin
                        byte_idx_next_s = byte_idx_r + 5'd1;
                        state_next_s    = START;
                    end else if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        state_next_s = LOAD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + CW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // tx follows the state being entered so the line is driven straight from a flop.
        case (state_next_s)
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = cur_byte_s[bit_idx_next_s];
            default: tx_next_s = 1'b1;
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            byte_idx_r <= 5'd0;
            bit_idx_r  <= 3'd0;
            clk_cnt_r  <= {CW{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            byte_idx_r <= byte_idx_next_s;
            bit_idx_r  <= bit_idx_next_s;
            clk_cnt_r  <= clk_cnt_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != IDLE) | (count_next_s != {CNTW{1'b0}});
        end
    end

    assign tx            = tx_r;
    assign busy          = busy_r;
    assign fifo_full     = fifo_full_r;
    assign dropped_count = dropped_r;

endmodule
